// File: rtl/instr_encode_loader.sv
// instr_encode_loader
//   Program loader that turns symbolic instruction tuples (class + fields) into
//   32-bit MIPS words for the Control decoder's instruction set. Each word is
//   written to instruction memory at an incrementing word address, starting at
//   BASE_ADDR after every start.
//
// Ports
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   start               begin a load (honoured only while idle)
//   in_valid/in_ready   tuple handshake; in_class + in_rs/in_rt/in_rd/in_shamt,
//                       in_imm, in_target form the tuple, in_last ends the program
//   out_valid/out_ready memory-write handshake carrying out_addr/out_word
//   busy                a load is in progress
//   done                one-cycle pulse when the load has fully drained
//   err                 sticky: illegal class or overflow seen (cleared by start)
//   count               words emitted during the current load
module instr_encode_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              enc_legal;
  logic [31:0]       enc_word;
  logic              emit;

  function automatic logic [31:0] r_fmt(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_fmt(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Returns {legal, word}; fields a format does not use are forced to zero.
  function automatic logic [32:0] encode(input logic [4:0] cls, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [15:0] imm,
                                         input logic [25:0] tgt);
    logic [32:0] r;
    r = {1'b1, 32'h0};
    case (cls)
      5'd0:    r[31:0] = r_fmt(rs, rt, rd, 5'd0, 6'h20);
      5'd1:    r[31:0] = r_fmt(rs, rt, rd, 5'd0, 6'h21);
      5'd2:    r[31:0] = r_fmt(rs, rt, rd, 5'd0, 6'h22);
      5'd3:    r[31:0] = r_fmt(rs, rt, rd, 5'd0, 6'h24);
      5'd4:    r[31:0] = r_fmt(rs, rt, rd, 5'd0, 6'h25);
      5'd5:    r[31:0] = r_fmt(rs, rt, rd, 5'd0, 6'h27);
      5'd6:    r[31:0] = r_fmt(rs, rt, rd, 5'd0, 6'h2A);
      5'd7:    r[31:0] = r_fmt(rs, rt, rd, 5'd0, 6'h2B);
      5'd8:    r[31:0] = r_fmt(5'd0, rt, rd, sh, 6'h00);
      5'd9:    r[31:0] = r_fmt(5'd0, rt, rd, sh, 6'h02);
      5'd10:   r[31:0] = r_fmt(5'd0, rt, rd, sh, 6'h03);
      5'd11:   r[31:0] = r_fmt(rs, rt, rd, 5'd0, 6'h07);
      5'd12:   r[31:0] = r_fmt(rs, 5'd0, 5'd0, 5'd0, 6'h08);
      5'd13:   r[31:0] = r_fmt(5'd0, 5'd0, 5'd0, 5'd0, 6'h0C);
      5'd14:   r[31:0] = i_fmt(6'h08, rs, rt, imm);
      5'd15:   r[31:0] = i_fmt(6'h09, rs, rt, imm);
      5'd16:   r[31:0] = i_fmt(6'h0C, rs, rt, imm);
      5'd17:   r[31:0] = i_fmt(6'h0D, rs, rt, imm);
      5'd18:   r[31:0] = i_fmt(6'h0A, rs, rt, imm);
      5'd19:   r[31:0] = i_fmt(6'h23, rs, rt, imm);
      5'd20:   r[31:0] = i_fmt(6'h2B, rs, rt, imm);
      5'd21:   r[31:0] = i_fmt(6'h20, rs, rt, imm);
      5'd22:   r[31:0] = i_fmt(6'h04, rs, rt, imm);
      5'd23:   r[31:0] = i_fmt(6'h05, rs, rt, imm);
      5'd24:   r[31:0] = i_fmt(6'h01, rs, 5'd0, imm);
      5'd25:   r[31:0] = {6'h02, tgt};
      5'd26:   r[31:0] = {6'h03, tgt};
      default: r       = {1'b0, 32'h0};
    endcase
    return r;
  endfunction

  always_comb begin
    {enc_legal, enc_word} = encode(in_class, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
  end

  assign accept = in_valid && in_ready;
  // A tuple only produces a word when its class is legal and there is room left.
  assign emit   = accept && enc_legal && (count != DEPTH_C);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (accept && in_last) state_nxt = S_FLUSH;
      S_FLUSH: if (!out_valid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    in_ready = (state == S_LOAD) && (!out_valid || out_ready);
  end

  // Output register, address and bookkeeping
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_word  <= 32'h0;
      out_addr  <= BASE_C;
      addr      <= BASE_C;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        err   <= 1'b0;
        count <= '0;
        addr  <= BASE_C;
      end
      // Drain first; a simultaneous new word below overrides the clear.
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !emit) err <= 1'b1;
      if (emit) begin
        out_valid <= 1'b1;
        out_word  <= enc_word;
        out_addr  <= addr;
        addr      <= addr + 1'b1;
        count     <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
module tb_instr_encode_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_class = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, busy, done, err;
  logic [9:0]  out_addr;
  logic [31:0] out_word;
  logic [10:0] count;

  logic        in_ready4, out_valid4, busy4, done4, err4;
  logic [9:0]  out_addr4;
  logic [31:0] out_word4;
  logic [10:0] count4;

  always #5 CLK = ~CLK;

  instr_encode_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(1024)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_word(out_word), .busy(busy),
    .done(done), .err(err), .count(count));

  instr_encode_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .out_valid(out_valid4),
    .out_ready(out_ready), .out_addr(out_addr4), .out_word(out_word4), .busy(busy4),
    .done(done4), .err(err4), .count(count4));

  typedef struct {
    logic [4:0]  cls, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] word;
  } wr_t;

  // Reference: per class, format (0=R,1=I,2=J), opcode/funct, and which fields survive.
  typedef struct {
    int         fmt;
    logic [5:0] code;
    bit         k_rs, k_rt, k_rd, k_sh;
  } spec_t;

  spec_t spec [27];
  wr_t   exp_q[$], got_q[$], got4_q[$];
  int    m_count;
  bit    m_err;
  int    checks = 0, errors = 0;
  bit    rand_ready = 0;
  vec_t  tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic void fill_spec();
    // R-type: ALU ops keep rs/rt/rd; shifts by constant keep rt/rd/shamt.
    logic [5:0] fn [14] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
                            6'h00, 6'h02, 6'h03, 6'h07, 6'h08, 6'h0C};
    logic [5:0] op [11] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h20,
                            6'h04, 6'h05, 6'h01};
    for (int c = 0; c < 14; c++) begin
      spec[c] = '{0, fn[c], 1, 1, 1, 0};
      if (c >= 8 && c <= 10) spec[c] = '{0, fn[c], 0, 1, 1, 1};
      if (c == 12) spec[c] = '{0, fn[c], 1, 0, 0, 0};
      if (c == 13) spec[c] = '{0, fn[c], 0, 0, 0, 0};
    end
    for (int c = 14; c < 25; c++) spec[c] = '{1, op[c-14], 1, (c != 24), 0, 0};
    spec[25] = '{2, 6'h02, 0, 0, 0, 0};
    spec[26] = '{2, 6'h03, 0, 0, 0, 0};
  endfunction

  function automatic logic [31:0] ref_word(input vec_t v);
    spec_t s = spec[v.cls];
    logic [4:0] rs = s.k_rs ? v.rs : 5'd0;
    logic [4:0] rt = s.k_rt ? v.rt : 5'd0;
    logic [4:0] rd = s.k_rd ? v.rd : 5'd0;
    logic [4:0] sh = s.k_sh ? v.sh : 5'd0;
    if (s.fmt == 0) return {6'd0, rs, rt, rd, sh, s.code};
    if (s.fmt == 1) return {s.code, rs, rt, v.imm};
    return {s.code, v.tgt};
  endfunction

  // Monitor: inputs change just after rising edges, so values at the falling
  // edge are exactly what the next rising edge will act on.
  always @(negedge CLK) begin
    if (RST_N && in_valid && in_ready) begin
      vec_t v;
      v = '{in_class, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, 32'h0};
      if (in_class > 5'd26 || m_count >= 1024) m_err = 1;
      else begin
        exp_q.push_back('{10'(m_count), ref_word(v)});
        m_count++;
      end
    end
    if (RST_N && out_valid && out_ready) got_q.push_back('{out_addr, out_word});
    if (RST_N && out_valid4 && out_ready) got4_q.push_back('{out_addr4, out_word4});
  end

  always @(posedge CLK) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic clear_model();
    exp_q.delete(); got_q.delete(); got4_q.delete();
    m_count = 0; m_err = 0;
  endtask

  task automatic do_start();
    clear_model();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic last);
    bit ok = 0;
    in_class = v.cls; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_shamt = v.sh;
    in_imm = v.imm; in_target = v.tgt; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      ok = in_ready;
      @(posedge CLK); #1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic finish_load(input string tag);
    int  nd = 0;
    bit  prev = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (prev) chk({tag, "_busy_after_done"}, busy, 0);
      prev = done;
      if (done) nd++;
      if (!busy && nd > 0) break;
    end
    repeat (3) begin @(negedge CLK); if (done) nd++; end
    chk({tag, "_done_pulses"}, nd, 1);
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_word%0d", tag, i), got_q[i].word, exp_q[i].word);
    end
    chk({tag, "_count"}, count, m_count);
    chk({tag, "_err"}, err, m_err);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_word"}, out_word, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_count"}, count, 0);
  endtask

  initial begin
    vec_t a, b, v;
    fill_spec();
    tbl[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'h00221820};
    tbl[1]  = '{5'd14, 5'd1,  5'd2,  5'd7,  5'd3,  16'h0005, 26'h0,       32'h20220005};
    tbl[2]  = '{5'd19, 5'd29, 5'd8,  5'd0,  5'd0,  16'h0004, 26'h0,       32'h8FA80004};
    tbl[3]  = '{5'd25, 5'd5,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0100000, 32'h08100000};
    tbl[4]  = '{5'd13, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0,       32'h0000000C};
    tbl[5]  = '{5'd8,  5'd5,  5'd2,  5'd3,  5'd4,  16'h0000, 26'h0,       32'h00021900};
    tbl[6]  = '{5'd24, 5'd4,  5'd7,  5'd0,  5'd0,  16'hFFFF, 26'h0,       32'h0480FFFF};
    tbl[7]  = '{5'd12, 5'd31, 5'd1,  5'd1,  5'd1,  16'h0000, 26'h0,       32'h03E00008};
    tbl[8]  = '{5'd1,  5'd1,  5'd2,  5'd3,  5'd5,  16'h0000, 26'h0,       32'h00221821};
    tbl[9]  = '{5'd26, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
    tbl[10] = '{5'd11, 5'd2,  5'd3,  5'd4,  5'd9,  16'h0000, 26'h0,       32'h00432007};
    tbl[11] = '{5'd23, 5'd1,  5'd2,  5'd0,  5'd0,  16'h8000, 26'h0,       32'h14228000};

    // Reset state
    repeat (3) @(posedge CLK);
    #1 check_reset("reset");
    RST_N = 1'b1;

    // Table of encodings, streamed back to back
    do_start();
    for (int i = 0; i < 12; i++) send(tbl[i], i == 11);
    finish_load("tbl");
    chk("tbl_nwords", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      chk($sformatf("tbl_word%0d", i), got_q[i].word, tbl[i].exp);
      chk($sformatf("tbl_addr%0d", i), got_q[i].addr, i);
    end
    chk("tbl_count", count, 12);
    chk("tbl_err", err, 0);

    // Back-pressure: one word held stable while the next tuple waits
    out_ready = 1'b0;
    do_start();
    a = tbl[0];
    b = tbl[2];
    send(a, 1'b0);
    chk("stall_count1", count, 1);
    in_class = b.cls; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd; in_shamt = b.sh;
    in_imm = b.imm; in_target = b.tgt; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("stall_in_ready%0d", i), in_ready, 0);
      chk($sformatf("stall_valid%0d", i), out_valid, 1);
      chk($sformatf("stall_word%0d", i), out_word, 32'h00221820);
      chk($sformatf("stall_addr%0d", i), out_addr, 0);
    end
    @(posedge CLK); #1 out_ready = 1'b1;
    send(b, 1'b1);
    finish_load("stall");
    compare_model("stall");

    // Illegal class followed by the last tuple
    do_start();
    v = tbl[0]; v.cls = 5'd30;
    send(v, 1'b0);
    send(tbl[0], 1'b1);
    finish_load("illegal");
    compare_model("illegal");
    chk("illegal_err_set", err, 1);

    // Randomized program with random gaps and random back-pressure
    do_start();
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      v.cls = 5'($urandom_range(0, 31)); v.rs = 5'($urandom); v.rt = 5'($urandom);
      v.rd = 5'($urandom); v.sh = 5'($urandom); v.imm = 16'($urandom);
      v.tgt = 26'($urandom); v.exp = 32'h0;
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #0 send(v, i == 299);
    end
    finish_load("rand");
    rand_ready = 0;
    @(posedge CLK); #2 out_ready = 1'b1;
    compare_model("rand");

    // Overflow on a DEPTH=4 instance: 6 tuples -> 4 words
    RST_N = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b1;
    do_start();
    for (int i = 0; i < 6; i++) begin
      v = tbl[(i * 5) % 12];
      send(v, i == 5);
    end
    finish_load("ovf");
    compare_model("ovf_big");
    chk("ovf_nwords", got4_q.size(), 4);
    for (int i = 0; i < 4 && i < got4_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("ovf_addr%0d", i), got4_q[i].addr, i);
      chk($sformatf("ovf_word%0d", i), got4_q[i].word, exp_q[i].word);
    end
    chk("ovf_err", err4, 1);
    chk("ovf_count", count4, 4);
    chk("ovf_idle", busy4, 0);

    // Asynchronous reset in the middle of a stalled stream
    out_ready = 1'b0;
    do_start();
    send(tbl[1], 1'b0);
    in_valid = 1'b1;
    @(posedge CLK); #3 RST_N = 1'b0;
    #1 check_reset("midreset");
    in_valid = 1'b0;
    clear_model();
    @(posedge CLK); #1 RST_N = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    chk("post_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
